// File: rtl/spike_reconstructor_pkg.sv
// Purpose: shared spike codes, FSM state encoding and width defaults for the
//          spike reconstructor and its companion delta encoder.
// Latency/backpressure: n/a (types and constants only).
// Contents: DATA_W_DEF, CNT_W_DEF, spike_e, state_e.
package spike_reconstructor_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    // 2-bit spike code as emitted by the delta encoder.
    typedef enum logic [1:0] {
        SPK_NONE = 2'b00,
        SPK_ON   = 2'b01,
        SPK_OFF  = 2'b10,
        SPK_ILL  = 2'b11
    } spike_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/spike_reconstructor_if.sv
// Purpose: bundles the spike input, control inputs and reconstruction outputs.
// Latency: n/a (wires only). Backpressure: none, spikes are fire-and-forget.
// Modports: master drives spike/control and observes results; slave is the reconstructor.
interface spike_reconstructor_if
    import spike_reconstructor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              spike_valid;
    logic [1:0]        spike;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] baseline;
    logic              load;
    logic [CNT_W-1:0]  leak_period;

    logic [DATA_W-1:0] recon;
    logic              recon_valid;
    logic              sat;
    logic              err;
    logic [CNT_W-1:0]  on_count;
    logic [CNT_W-1:0]  off_count;

    modport master (
        output spike_valid, spike, threshold, baseline, load, leak_period,
        input  recon, recon_valid, sat, err, on_count, off_count
    );

    modport slave (
        input  spike_valid, spike, threshold, baseline, load, leak_period,
        output recon, recon_valid, sat, err, on_count, off_count
    );
endinterface

// File: rtl/spike_reconstructor_sat_counter.sv
// Purpose: W-bit up counter that sticks at all-ones; clear has priority over increment.
// Latency: count visible one clock after inc/clr. Backpressure: none.
// Ports: clk, rst_n, clr, inc in; cnt out.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/spike_reconstructor.sv
// Purpose: rebuilds a sample stream from on/off delta spikes, with leak back to baseline.
// Latency: 1 clock, spike sampled on an edge is reflected in recon/recon_valid after that edge.
// Backpressure: none; every spike is consumed in the cycle it is presented.
// Ports: clk, rst_n plain; bus (slave modport) carries spike/control in and recon/status out.
module spike_reconstructor
    import spike_reconstructor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spike_reconstructor_if.slave  bus
);
    localparam logic [DATA_W:0] MAX_EXT = {1'b0, {DATA_W{1'b1}}};

    // ---------------- FSM ----------------
    state_e state_q;
    state_e state_d;
    logic   run_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // load is the only way in and RUN is never left except by reset.
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        run_en = (state_q == ST_RUN);
    end

    // ---------------- spike decode ----------------
    logic spk_ill;
    logic acc_on;
    logic acc_off;
    logic idle_run;
    logic leak_hit;
    logic leak_clr;
    logic leak_inc;

    logic [CNT_W-1:0] on_cnt;
    logic [CNT_W-1:0] off_cnt;
    logic [CNT_W-1:0] leak_cnt;

    always_comb begin
        spk_ill  = bus.spike_valid && (bus.spike == SPK_ILL);
        // load shadows any same-cycle spike: it is neither applied nor counted.
        acc_on   = run_en && !bus.load && bus.spike_valid && (bus.spike == SPK_ON);
        acc_off  = run_en && !bus.load && bus.spike_valid && (bus.spike == SPK_OFF);
        idle_run = run_en && !bus.load && !acc_on && !acc_off;
        // >= rather than == so a shortened leak_period fires on the next compare
        // instead of waiting for the saturated counter.
        leak_hit = idle_run && (bus.leak_period != '0) &&
                   (leak_cnt >= (bus.leak_period - CNT_W'(1)));
        leak_clr = bus.load || acc_on || acc_off || leak_hit;
        leak_inc = idle_run && !leak_hit;
    end

    sat_counter #(.W(CNT_W)) u_on_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (acc_on),
        .cnt   (on_cnt)
    );

    sat_counter #(.W(CNT_W)) u_off_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (acc_off),
        .cnt   (off_cnt)
    );

    sat_counter #(.W(CNT_W)) u_leak_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (leak_clr),
        .inc   (leak_inc),
        .cnt   (leak_cnt)
    );

    // ---------------- datapath ----------------
    logic [DATA_W-1:0] recon_q;
    logic [DATA_W-1:0] recon_d;
    logic              recon_valid_q;
    logic              recon_valid_d;
    logic              sat_q;
    logic              sat_d;
    logic              err_q;
    logic              err_d;

    logic [DATA_W:0]   sum_up;
    logic [DATA_W:0]   diff_dn;
    logic              up_clip;
    logic              dn_clip;
    logic [DATA_W-1:0] recon_up;
    logic [DATA_W-1:0] recon_dn;
    logic [DATA_W-1:0] recon_leak;

    always_comb begin
        // One extra bit holds the carry of recon + threshold + 1.
        sum_up   = {1'b0, recon_q} + {1'b0, bus.threshold} + (DATA_W+1)'(1);
        up_clip  = (sum_up > MAX_EXT);
        recon_up = up_clip ? {DATA_W{1'b1}} : sum_up[DATA_W-1:0];

        // The true difference lies in [-2^DATA_W, 2^DATA_W-1], so the extra MSB
        // is exactly the sign of a DATA_W+1 bit two's-complement result.
        diff_dn  = {1'b0, recon_q} - {1'b0, bus.threshold} - (DATA_W+1)'(1);
        dn_clip  = diff_dn[DATA_W];
        recon_dn = dn_clip ? '0 : diff_dn[DATA_W-1:0];

        if (recon_q > bus.baseline) begin
            recon_leak = recon_q - DATA_W'(1);
        end else if (recon_q < bus.baseline) begin
            recon_leak = recon_q + DATA_W'(1);
        end else begin
            recon_leak = recon_q;
        end
    end

    always_comb begin
        recon_d       = recon_q;
        recon_valid_d = 1'b0;
        sat_d         = sat_q;
        err_d         = err_q | spk_ill;

        if (bus.load) begin
            recon_d = bus.baseline;
        end else if (acc_on) begin
            recon_d       = recon_up;
            recon_valid_d = (recon_up != recon_q);
            sat_d         = sat_q | up_clip;
        end else if (acc_off) begin
            recon_d       = recon_dn;
            recon_valid_d = (recon_dn != recon_q);
            sat_d         = sat_q | dn_clip;
        end else if (leak_hit) begin
            recon_d       = recon_leak;
            recon_valid_d = (recon_leak != recon_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recon_q       <= '0;
            recon_valid_q <= 1'b0;
            sat_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            recon_q       <= recon_d;
            recon_valid_q <= recon_valid_d;
            sat_q         <= sat_d;
            err_q         <= err_d;
        end
    end

    assign bus.recon       = recon_q;
    assign bus.recon_valid = recon_valid_q;
    assign bus.sat         = sat_q;
    assign bus.err         = err_q;
    assign bus.on_count    = on_cnt;
    assign bus.off_count   = off_cnt;
endmodule

// File: tb/tb_spike_reconstructor.sv
// Purpose: self-checking bench for spike_reconstructor: directed vector table,
//          a short hand sequence, then randomized traffic against a reference model.
// Latency/backpressure: checks sampled 1 time unit after each rising edge.
module tb_spike_reconstructor;
    import spike_reconstructor_pkg::*;

    localparam int DW = 4;
    localparam int CW = 8;

    logic clk;
    logic rst_n;

    spike_reconstructor_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    spike_reconstructor #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          ld;
        bit          sv;
        bit [1:0]    spk;
        bit [DW-1:0] thr;
        bit [DW-1:0] base;
        bit [CW-1:0] lp;
        bit [DW-1:0] e_recon;
        bit          e_rv;
        bit          e_sat;
        bit [CW-1:0] e_on;
        bit [CW-1:0] e_off;
        bit          e_err;
    } vec_t;

    function automatic vec_t mk(bit rst, bit ld, bit sv, bit [1:0] spk, bit [DW-1:0] thr,
                                bit [DW-1:0] base, bit [CW-1:0] lp, bit [DW-1:0] r, bit rv,
                                bit s, bit [CW-1:0] on, bit [CW-1:0] off, bit e);
        vec_t v;
        v.rst = rst; v.ld = ld; v.sv = sv; v.spk = spk; v.thr = thr; v.base = base; v.lp = lp;
        v.e_recon = r; v.e_rv = rv; v.e_sat = s; v.e_on = on; v.e_off = off; v.e_err = e;
        return v;
    endfunction

    task automatic drive(input bit ld, input bit sv, input bit [1:0] spk, input bit [DW-1:0] thr,
                         input bit [DW-1:0] base, input bit [CW-1:0] lp);
        bus.load        = ld;
        bus.spike_valid = sv;
        bus.spike       = spk;
        bus.threshold   = thr;
        bus.baseline    = base;
        bus.leak_period = lp;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " recon"},       32'(bus.recon),       32'(v.e_recon));
        check({tag, " recon_valid"}, 32'(bus.recon_valid), 32'(v.e_rv));
        check({tag, " sat"},         32'(bus.sat),         32'(v.e_sat));
        check({tag, " err"},         32'(bus.err),         32'(v.e_err));
        check({tag, " on_count"},    32'(bus.on_count),    32'(v.e_on));
        check({tag, " off_count"},   32'(bus.off_count),   32'(v.e_off));
    endtask

    // ---------------- reference model state ----------------
    int m_run, m_recon, m_leak, m_on, m_off, m_sat, m_err, m_rv;

    task automatic model_reset();
        m_run = 0; m_recon = 0; m_leak = 0; m_on = 0; m_off = 0;
        m_sat = 0; m_err = 0; m_rv = 0;
    endtask

    task automatic model_step(input int ld, input int sv, input int spk, input int thr,
                              input int base, input int lp);
        int nxt;
        m_rv = 0;
        if (sv != 0 && spk == 3) m_err = 1;
        if (ld != 0) begin
            m_recon = base; m_run = 1; m_leak = 0;
        end else if (m_run != 0) begin
            if (sv != 0 && spk == 1) begin
                nxt = m_recon + thr + 1;
                if (nxt > (1 << DW) - 1) begin nxt = (1 << DW) - 1; m_sat = 1; end
                m_rv = (nxt != m_recon); m_recon = nxt; m_leak = 0;
                if (m_on < (1 << CW) - 1) m_on++;
            end else if (sv != 0 && spk == 2) begin
                nxt = m_recon - thr - 1;
                if (nxt < 0) begin nxt = 0; m_sat = 1; end
                m_rv = (nxt != m_recon); m_recon = nxt; m_leak = 0;
                if (m_off < (1 << CW) - 1) m_off++;
            end else if (lp != 0 && m_leak == lp - 1) begin
                nxt = (m_recon > base) ? m_recon - 1 : (m_recon < base) ? m_recon + 1 : m_recon;
                m_rv = (nxt != m_recon); m_recon = nxt; m_leak = 0;
            end else if (m_leak < (1 << CW) - 1) begin
                m_leak++;
            end
        end
    endtask

    vec_t vt[$];

    initial begin
        bit [DW-1:0] lr;
        bit          lrv;
        int          r_ld, r_sv, r_spk, r_thr, r_base, r_lp;
        logic [31:0] act, exp;

        // ---------------- directed vector table ----------------
        //          rst ld sv spk thr base lp  recon rv sat on off err
        vt.push_back(mk(0, 0, 1, 1, 2,  8, 0,   0, 0, 0, 0, 0, 0)); // IDLE: on ignored
        vt.push_back(mk(0, 0, 1, 2, 2,  8, 0,   0, 0, 0, 0, 0, 0)); // IDLE: off ignored
        vt.push_back(mk(0, 1, 0, 0, 2,  8, 0,   8, 0, 0, 0, 0, 0)); // load 8
        vt.push_back(mk(0, 0, 1, 1, 2,  8, 0,  11, 1, 0, 1, 0, 0)); // 8+3
        vt.push_back(mk(0, 0, 1, 2, 2,  8, 0,   8, 1, 0, 1, 1, 0)); // 11-3
        vt.push_back(mk(0, 1, 0, 0, 3, 14, 0,  14, 0, 0, 1, 1, 0)); // load 14
        vt.push_back(mk(0, 0, 1, 1, 3, 14, 0,  15, 1, 1, 2, 1, 0)); // clip at top
        vt.push_back(mk(0, 0, 1, 1, 3, 14, 0,  15, 0, 1, 3, 1, 0)); // at rail: no change
        vt.push_back(mk(1, 0, 0, 0, 1,  2, 0,   0, 0, 0, 0, 0, 0)); // async reset
        vt.push_back(mk(0, 1, 0, 0, 1,  2, 0,   2, 0, 0, 0, 0, 0)); // load 2
        vt.push_back(mk(0, 0, 1, 2, 1,  2, 0,   0, 1, 0, 0, 1, 0)); // exact landing on 0
        vt.push_back(mk(0, 0, 1, 2, 1,  2, 0,   0, 0, 1, 0, 2, 0)); // clip at 0
        vt.push_back(mk(0, 0, 1, 3, 1,  2, 0,   0, 0, 1, 0, 2, 1)); // illegal code
        vt.push_back(mk(0, 0, 0, 1, 1,  2, 0,   0, 0, 1, 0, 2, 1)); // not valid: idle
        vt.push_back(mk(0, 1, 1, 1, 2,  5, 0,   5, 0, 1, 0, 2, 1)); // load beats spike
        vt.push_back(mk(0, 1, 0, 0, 2,  8, 0,   8, 0, 1, 0, 2, 1)); // load 8
        vt.push_back(mk(0, 0, 1, 1, 2,  8, 0,  11, 1, 1, 1, 2, 1)); // 11
        for (int i = 1; i <= 18; i++) begin                          // leak, period 4
            lr  = (i < 4) ? 4'd11 : (i < 8) ? 4'd10 : (i < 12) ? 4'd9 : 4'd8;
            lrv = (i == 4) || (i == 8) || (i == 12);
            vt.push_back(mk(0, 0, 0, 0, 2, 8, 4, lr, lrv, 1, 1, 2, 1));
        end
        vt.push_back(mk(1, 0, 0, 0, 2,  8, 4,   0, 0, 0, 0, 0, 0)); // reset mid-leak
        vt.push_back(mk(0, 0, 1, 1, 2,  8, 4,   0, 0, 0, 0, 0, 0)); // back in IDLE
        vt.push_back(mk(0, 0, 1, 3, 2,  8, 4,   0, 0, 0, 0, 0, 1)); // err in IDLE
        vt.push_back(mk(0, 1, 0, 0, 2,  3, 4,   3, 0, 0, 0, 0, 1)); // load keeps err

        rst_n = 1'b0;
        drive(0, 0, 2'd0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) begin
                rst_n = 1'b0;
                #1;
                check_all($sformatf("row%0d", i), vt[i]);
                rst_n = 1'b1;
            end else begin
                drive(vt[i].ld, vt[i].sv, vt[i].spk, vt[i].thr, vt[i].base, vt[i].lp);
                @(posedge clk);
                #1;
                check_all($sformatf("row%0d", i), vt[i]);
            end
        end

        // ---------------- hand sequence: period-1 leak upward ----------------
        drive(1, 0, 2'd0, 4'd1, 4'd6, 8'd1);
        @(posedge clk); #1;
        check("seq load", 32'(bus.recon), 32'd6);
        drive(0, 1, 2'd2, 4'd1, 4'd6, 8'd1);
        @(posedge clk); #1;
        check("seq off", 32'(bus.recon), 32'd4);
        drive(0, 0, 2'd0, 4'd1, 4'd6, 8'd1);
        @(posedge clk); #1;
        check("seq leak1", {31'(bus.recon), bus.recon_valid}, {31'd5, 1'b1});
        @(posedge clk); #1;
        check("seq leak2", {31'(bus.recon), bus.recon_valid}, {31'd6, 1'b1});
        @(posedge clk); #1;
        check("seq leak3", {31'(bus.recon), bus.recon_valid}, {31'd6, 1'b0});

        // ---------------- randomized traffic vs reference model ----------------
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        r_base = 0;
        r_lp   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                model_reset();
            end
            r_ld = ($urandom_range(0, 99) < 4) ? 1 : 0;
            if (r_ld != 0) begin
                r_base = $urandom_range(0, 15);
                case ($urandom_range(0, 4))
                    0:       r_lp = 0;
                    1:       r_lp = 1;
                    2:       r_lp = 2;
                    3:       r_lp = 3;
                    default: r_lp = 6;
                endcase
            end
            r_sv  = ($urandom_range(0, 99) < 60) ? 1 : 0;
            r_spk = $urandom_range(0, 3);
            r_thr = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            drive(r_ld[0], r_sv[0], r_spk[1:0], r_thr[DW-1:0], r_base[DW-1:0], r_lp[CW-1:0]);
            model_step(r_ld, r_sv, r_spk, r_thr, r_base, r_lp);
            @(posedge clk);
            #1;
            act = {9'd0, bus.recon, bus.recon_valid, bus.sat, bus.err, bus.on_count, bus.off_count};
            exp = {9'd0, DW'(m_recon), m_rv[0], m_sat[0], m_err[0], CW'(m_on), CW'(m_off)};
            check($sformatf("rand c%0d {recon,rv,sat,err,on,off}", c), act, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spike_reconstructor.md
SPIKE_RECONSTRUCTOR -- requirements
Module: spike_reconstructor

Interface
REQ-001 Parameters: DATA_W, default 4, width of reconstructed sample, threshold and baseline.
REQ-002 Parameters: CNT_W, default 8, width of on/off spike counters and leak counter.
REQ-003 Ports: clk input 1, the single clock; all state updates on its rising edge.
REQ-004 Ports: rst_n input 1, reset, asynchronous, active-low.
REQ-005 Ports: spike_valid input 1, qualifies spike this cycle.
REQ-006 Ports: spike input 2, 01 = on (rising), 10 = off (falling), 00 = none, 11 = illegal.
REQ-007 Ports: threshold input DATA_W, encoder threshold; reconstruction step = threshold+1.
REQ-008 Ports: baseline input DATA_W, value loaded on load and target of leak decay.
REQ-009 Ports: load input 1, one-cycle strobe: recon <= baseline, enter RUN.
REQ-010 Ports: leak_period input CNT_W, idle cycles per leak step; 0 disables leak.
REQ-011 Ports: recon output DATA_W, registered reconstructed sample.
REQ-012 Ports: recon_valid output 1, one-cycle pulse when recon changed value due to spike or leak.
REQ-013 Ports: sat output 1, sticky, set when a step was clipped at 0 or 2^DATA_W-1.
REQ-014 Ports: err output 1, sticky, set on spike_valid with spike = 11.
REQ-015 Ports: on_count, off_count outputs CNT_W each, accepted-spike counters, saturating at all-ones.

Function
REQ-016 FSM states IDLE and RUN; reset enters IDLE; load moves to RUN from either state; no other transition.
REQ-017 In IDLE, spikes and leak are ignored; counters and recon hold; err still captures illegal codes.
REQ-018 In RUN, on spike (valid, 01): recon <= min(recon + threshold + 1, 2^DATA_W-1), computed at DATA_W+1 bits.
REQ-019 In RUN, on spike (valid, 10): recon <= max(recon - threshold - 1, 0), computed at DATA_W+1 bits signed.
REQ-020 Clipping in REQ-018/019 sets sat; exact landing on 0 or max is not clipping.
REQ-021 Spike 00 or spike_valid = 0 is an idle cycle; spike 11 is treated as idle plus err.
REQ-022 Latency: recon and recon_valid update on the edge that samples the spike (one clock from input to registered output).
REQ-023 recon_valid asserts only if the new recon differs from old; a clipped step already at the rail gives recon_valid = 0, sat = 1.
REQ-024 Leak counter counts consecutive RUN idle cycles; any accepted on/off spike or load clears it.
REQ-025 When leak_period != 0 and leak counter reaches leak_period - 1 on an idle cycle: recon moves 1 LSB toward baseline, counter clears; if recon == baseline, no change and counter clears.
REQ-026 Leak counter saturates; leak_period change takes effect on the next compare.
REQ-027 load in the same cycle as a spike: load wins, spike ignored and not counted, recon_valid = 0.
REQ-028 load clears leak counter but not on_count, off_count, sat, err.
REQ-029 on_count/off_count increment once per accepted spike in RUN; hold at all-ones.
REQ-030 threshold sampled every cycle; no internal copy.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, recon 0, recon_valid 0, sat 0, err 0, on_count 0, off_count 0, leak counter 0.
REQ-032 Reset asserted mid-operation discards all state; first edge after release behaves as IDLE.

Structure
REQ-033 Shared package holds spike codes (SPK_NONE, SPK_ON, SPK_OFF, SPK_ILL), FSM state enum, and DATA_W/CNT_W defaults, shared with the delta encoder.
REQ-034 One sub-module, sat_counter (CNT_W saturating incrementer with clear), instantiated for on_count, off_count and leak counter.

Verification
REQ-035 Reset, load baseline=8, threshold=2, one on spike -> recon 11 next edge, recon_valid 1, on_count 1.
REQ-036 recon=14, threshold=3, on spike -> recon 15, sat 1, recon_valid 1; second on spike -> recon 15, recon_valid 0, on_count 2.
REQ-037 recon=2, threshold=1, off spike -> recon 0, sat 0; another off -> recon 0, sat 1.
REQ-038 baseline=8, recon=11, leak_period=4, no spikes -> recon 10, 9, 8 at idle cycles 4, 8, 12, then stays 8.
REQ-039 Spikes before any load -> recon 0, counters 0; spike 11 -> err 1 sticky until reset.
REQ-040 load with simultaneous on spike, baseline=5 -> recon 5, on_count unchanged; rst_n pulsed mid-leak -> all outputs 0 immediately.
